// File: rtl/rs_gf_pkg.sv
// Shared GF(2^m) types, FSM state encoding and reference arithmetic for the
// sequential RS multiplier slice.
package rs_gf_pkg;

   localparam int GF_MAX_M = 16;

   typedef logic [GF_MAX_M-1:0] gf_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Multiply by x: irrpol carries the x^m term, so XORing it clears bit m.
   function automatic gf_t gf_xtime(gf_t a, int unsigned irrpol, int unsigned m);
      logic [31:0] t;
      logic [31:0] mask;
      t    = {16'b0, a} << 1;
      mask = (32'd1 << m) - 32'd1;
      if (t[m]) begin
         t = t ^ irrpol;
      end
      return gf_t'(t & mask);
   endfunction

   function automatic gf_t gf_mult_ref(gf_t a, gf_t b, int unsigned irrpol, int unsigned m);
      gf_t r;
      gf_t x;
      r = '0;
      x = a;
      for (int i = 0; i < int'(m); i++) begin
         if (b[i]) begin
            r = r ^ x;
         end
         x = gf_xtime(x, irrpol, m);
      end
      return r;
   endfunction

endpackage

// File: rtl/rs_gf_mult_seq_step.sv
// One multiplier step: nbits MSB-first Horner iterations of acc = acc*x + bit*a
// over GF(2^m), purely combinational.
module rs_gf_mult_seq_step #(
   parameter int m      = 8,
   parameter int irrpol = 285,
   parameter int nbits  = 2
) (
   input  logic [m-1:0]     acc_in,
   input  logic [m-1:0]     a,
   input  logic [nbits-1:0] bsl,
   output logic [m-1:0]     acc_out
);

   localparam logic [m-1:0] POLY = irrpol[m-1:0];

   logic [m-1:0] t;

   // Highest slice bit is the most significant remaining bit of b.
   always_comb begin
      t = acc_in;
      for (int i = nbits - 1; i >= 0; i--) begin
         t = {t[m-2:0], 1'b0} ^ (t[m-1] ? POLY : '0) ^ (bsl[i] ? a : '0);
      end
      acc_out = t;
   end

endmodule

// File: rtl/rs_gf_mult_seq.sv
// Sequential GF(2^m) multiplier, nbits of b per cycle with valid/ready handshake.
// Optional multiply-accumulate mode enabled by defining RS_GF_MULT_SEQ_ACC_EN.
module rs_gf_mult_seq
   import rs_gf_pkg::*;
#(
   parameter int m      = 8,
   parameter int irrpol = 285,
   parameter int nbits  = 2
) (
   input  logic         iclk,
   input  logic         ireset_n,
   input  logic         iclkena,
   input  logic         ival,
   output logic         ordy,
   input  logic [m-1:0] idat_a,
   input  logic [m-1:0] idat_b,
`ifdef RS_GF_MULT_SEQ_ACC_EN
   input  logic         iacc,
`endif
   output logic         oval,
   output logic [m-1:0] odat
);

   localparam int NSTEP = (m + nbits - 1) / nbits;
   localparam int BW    = NSTEP * nbits;
   localparam int CW    = $clog2(NSTEP) + 1;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [m-1:0]    a_r;
   logic [m-1:0]    acc;
   logic [BW-1:0]   b_sr;
   logic [BW-1:0]   b_pad;
   logic [m-1:0]    st_acc;
   logic [m-1:0]    st_a;
   logic [nbits-1:0] st_b;
   logic [m-1:0]    nxt;
   logic [m-1:0]    result;
`ifdef RS_GF_MULT_SEQ_ACC_EN
   logic            acc_req;
   logic            use_acc;
`endif

   assign b_pad = BW'(idat_b);

   // The first step runs on the accept edge straight from the inputs, so a
   // result costs exactly NSTEP edges and accepts can come back to back.
   always_comb begin
      if (state == IDLE) begin
         st_acc = '0;
         st_a   = idat_a;
         st_b   = b_pad[BW-1 -: nbits];
      end else begin
         st_acc = acc;
         st_a   = a_r;
         st_b   = b_sr[BW-1 -: nbits];
      end
   end

   rs_gf_mult_seq_step #(
      .m      (m),
      .irrpol (irrpol),
      .nbits  (nbits)
   ) u_step (
      .acc_in  (st_acc),
      .a       (st_a),
      .bsl     (st_b),
      .acc_out (nxt)
   );

`ifdef RS_GF_MULT_SEQ_ACC_EN
   assign use_acc = (state == IDLE) ? iacc : acc_req;
   assign result  = nxt ^ (use_acc ? odat : '0);
`else
   assign result  = nxt;
`endif

   // Control FSM and datapath registers; iclkena low freezes everything.
   always_ff @(posedge iclk) begin
      if (!ireset_n) begin
         state <= IDLE;
         cnt   <= '0;
         a_r   <= '0;
         acc   <= '0;
         b_sr  <= '0;
         ordy  <= 1'b1;
         oval  <= 1'b0;
         odat  <= '0;
`ifdef RS_GF_MULT_SEQ_ACC_EN
         acc_req <= 1'b0;
`endif
      end else if (iclkena) begin
         oval <= 1'b0;
         case (state)
            IDLE: begin
               if (ival) begin
                  a_r  <= idat_a;
                  b_sr <= b_pad << nbits;
                  acc  <= nxt;
`ifdef RS_GF_MULT_SEQ_ACC_EN
                  acc_req <= iacc;
`endif
                  if (NSTEP == 1) begin
                     odat <= result;
                     oval <= 1'b1;
                  end else begin
                     cnt   <= CW'(NSTEP - 2);
                     state <= BUSY;
                     ordy  <= 1'b0;
                  end
               end
            end
            BUSY: begin
               acc  <= nxt;
               b_sr <= b_sr << nbits;
               if (cnt == '0) begin
                  odat  <= result;
                  oval  <= 1'b1;
                  ordy  <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ordy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs_gf_mult_seq.sv
// Directed bench for rs_gf_mult_seq: an m=8/nbits=2 instance plus a padded
// m=4/nbits=3 instance. Define RS_GF_MULT_SEQ_ACC_EN to also exercise the MAC mode.
module tb_rs_gf_mult_seq;
   import rs_gf_pkg::*;

   logic       iclk;
   logic       ireset_n;
   logic       iclkena;
   logic       ival;
   logic       ordy;
   logic [7:0] idat_a;
   logic [7:0] idat_b;
   logic       iacc;
   logic       oval;
   logic [7:0] odat;

   logic       m4_ena;
   logic       m4_ival;
   logic       m4_ordy;
   logic [3:0] m4_a;
   logic [3:0] m4_b;
   logic       m4_iacc;
   logic       m4_oval;
   logic [3:0] m4_odat;

   int checks = 0;
   int errors = 0;

   rs_gf_mult_seq #(.m(8), .irrpol(285), .nbits(2)) dut (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (iclkena),
      .ival     (ival),
      .ordy     (ordy),
      .idat_a   (idat_a),
      .idat_b   (idat_b),
`ifdef RS_GF_MULT_SEQ_ACC_EN
      .iacc     (iacc),
`endif
      .oval     (oval),
      .odat     (odat)
   );

   rs_gf_mult_seq #(.m(4), .irrpol(19), .nbits(3)) dut_m4 (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (m4_ena),
      .ival     (m4_ival),
      .ordy     (m4_ordy),
      .idat_a   (m4_a),
      .idat_b   (m4_b),
`ifdef RS_GF_MULT_SEQ_ACC_EN
      .iacc     (m4_iacc),
`endif
      .oval     (m4_oval),
      .odat     (m4_odat)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                         output logic [7:0] res, output int lat);
      int guard;
      guard = 0;
      while (!ordy && guard < 20) begin
         tick();
         guard++;
      end
      idat_a = ta;
      idat_b = tb;
      ival   = 1'b1;
      tick();
      ival = 1'b0;
      lat  = 1;
      while (!oval && lat < 20) begin
         tick();
         lat++;
      end
      res = oval ? odat : 8'hxx;
   endtask

   task automatic run_op_m4(input logic [3:0] ta, input logic [3:0] tb,
                            output logic [3:0] res, output int lat);
      int guard;
      guard = 0;
      while (!m4_ordy && guard < 20) begin
         tick();
         guard++;
      end
      m4_a    = ta;
      m4_b    = tb;
      m4_ival = 1'b1;
      tick();
      m4_ival = 1'b0;
      lat     = 1;
      while (!m4_oval && lat < 20) begin
         tick();
         lat++;
      end
      res = m4_oval ? m4_odat : 4'hx;
   endtask

   task automatic test_reset();
      ireset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (ordy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ordy got %b expected 1", ordy);
      end
      checks++;
      if (oval !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_oval got %b expected 0", oval);
      end
      checks++;
      if (odat !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_odat got %h expected 00", odat);
      end
      checks++;
      if (m4_ordy !== 1'b1 || m4_odat !== 4'h0) begin
         errors++;
         $display("[TB] FAIL reset_m4 got ordy=%b odat=%h expected ordy=1 odat=0", m4_ordy, m4_odat);
      end
      ireset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] va [4];
      logic [7:0] vb [4];
      logic [7:0] ve [4];
      logic [7:0] res;
      int lat;
      va = '{8'h02, 8'h03, 8'hFF, 8'hA7};
      vb = '{8'h80, 8'h03, 8'h00, 8'h01};
      ve = '{8'h1D, 8'h05, 8'h00, 8'hA7};
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], res, lat);
         checks++;
         if (res !== ve[i]) begin
            errors++;
            $display("[TB] FAIL basic_result[%0d] got %h expected %h", i, res, ve[i]);
         end
         checks++;
         if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL basic_latency[%0d] got %0d expected 4", i, lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic [7:0] ve [3];
      int nacc, nout, cyc, last_acc, low_run;
      bit acc_now;
      va = '{8'h02, 8'h03, 8'hA7};
      vb = '{8'h80, 8'h03, 8'h01};
      ve = '{8'h1D, 8'h05, 8'hA7};
      nacc = 0; nout = 0; cyc = 0; last_acc = -1; low_run = 0;
      tick();
      idat_a = va[0];
      idat_b = vb[0];
      ival   = 1'b1;
      while (nout < 3 && cyc < 60) begin
         acc_now = ordy && ival;
         tick();
         cyc++;
         if (acc_now) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc !== 4) begin
                  errors++;
                  $display("[TB] FAIL b2b_accept_spacing got %0d expected 4", cyc - last_acc);
               end
            end
            last_acc = cyc;
            nacc++;
            if (nacc < 3) begin
               idat_a = va[nacc];
               idat_b = vb[nacc];
            end else begin
               ival = 1'b0;
            end
         end
         if (oval) begin
            checks++;
            if (odat !== ve[nout]) begin
               errors++;
               $display("[TB] FAIL b2b_result[%0d] got %h expected %h", nout, odat, ve[nout]);
            end
            nout++;
         end
         if (!ordy) begin
            low_run++;
         end else if (low_run > 0) begin
            checks++;
            if (low_run !== 3) begin
               errors++;
               $display("[TB] FAIL b2b_ordy_low got %0d expected 3", low_run);
            end
            low_run = 0;
         end
      end
      ival = 1'b0;
      checks++;
      if (nout !== 3) begin
         errors++;
         $display("[TB] FAIL b2b_count got %0d expected 3", nout);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] res;
      int lat, seen;
      idat_a = 8'h55;
      idat_b = 8'h77;
      ival   = 1'b1;
      tick();
      ival = 1'b0;
      tick();
      ireset_n = 1'b0;
      tick();
      ireset_n = 1'b1;
      checks++;
      if (oval !== 1'b0 || ordy !== 1'b1 || odat !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midreset_state got oval=%b ordy=%b odat=%h expected oval=0 ordy=1 odat=00",
                  oval, ordy, odat);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (oval) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("[TB] FAIL midreset_spurious_oval got %0d expected 0", seen);
      end
      run_op(8'h03, 8'h03, res, lat);
      checks++;
      if (res !== 8'h05 || lat !== 4) begin
         errors++;
         $display("[TB] FAIL midreset_newop got %h lat %0d expected 05 lat 4", res, lat);
      end
   endtask

   task automatic test_clkena();
      int en_cnt, cyc;
      idat_a  = 8'h02;
      idat_b  = 8'h80;
      iclkena = 1'b1;
      ival    = 1'b1;
      tick();
      ival   = 1'b0;
      en_cnt = 1;
      cyc    = 0;
      while (!oval && cyc < 40) begin
         iclkena = (cyc % 2 == 1);
         tick();
         cyc++;
         if (iclkena) en_cnt++;
      end
      checks++;
      if (oval !== 1'b1 || odat !== 8'h1D) begin
         errors++;
         $display("[TB] FAIL clkena_result got oval=%b odat=%h expected oval=1 odat=1d", oval, odat);
      end
      checks++;
      if (en_cnt !== 4) begin
         errors++;
         $display("[TB] FAIL clkena_enabled_cycles got %0d expected 4", en_cnt);
      end
      iclkena = 1'b0;
      tick();
      checks++;
      if (oval !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clkena_oval_frozen got %b expected 1", oval);
      end
      iclkena = 1'b1;
      tick();
      checks++;
      if (oval !== 1'b0 || odat !== 8'h1D) begin
         errors++;
         $display("[TB] FAIL clkena_oval_drop got oval=%b odat=%h expected oval=0 odat=1d", oval, odat);
      end
   endtask

   task automatic test_m4_padded();
      logic [3:0] res;
      gf_t        ref_v;
      int         lat;
      run_op_m4(4'h2, 4'h8, res, lat);
      checks++;
      if (res !== 4'h3 || lat !== 2) begin
         errors++;
         $display("[TB] FAIL m4_2x8 got %h lat %0d expected 3 lat 2", res, lat);
      end
      run_op_m4(4'h2, 4'h9, res, lat);
      checks++;
      if (res !== 4'h1) begin
         errors++;
         $display("[TB] FAIL m4_2x9 got %h expected 1", res);
      end
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            ref_v = gf_mult_ref(gf_t'(i), gf_t'(j), 19, 4);
            run_op_m4(4'(i), 4'(j), res, lat);
            checks++;
            if (res !== ref_v[3:0]) begin
               errors++;
               $display("[TB] FAIL m4_sweep a=%h b=%h got %h expected %h", i, j, res, ref_v[3:0]);
            end
         end
      end
   endtask

`ifdef RS_GF_MULT_SEQ_ACC_EN
   task automatic test_acc();
      logic [7:0] res;
      int lat;
      iacc = 1'b0;
      run_op(8'h02, 8'h80, res, lat);
      checks++;
      if (res !== 8'h1D) begin
         errors++;
         $display("[TB] FAIL acc_first got %h expected 1d", res);
      end
      iacc = 1'b1;
      run_op(8'h03, 8'h03, res, lat);
      iacc = 1'b0;
      checks++;
      if (res !== 8'h18) begin
         errors++;
         $display("[TB] FAIL acc_mac got %h expected 18", res);
      end
   endtask
`endif

   initial begin
      ireset_n = 1'b0;
      iclkena  = 1'b1;
      ival     = 1'b0;
      idat_a   = '0;
      idat_b   = '0;
      iacc     = 1'b0;
      m4_ena   = 1'b1;
      m4_ival  = 1'b0;
      m4_a     = '0;
      m4_b     = '0;
      m4_iacc  = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_reset_mid();
      test_clkena();
      test_m4_padded();
`ifdef RS_GF_MULT_SEQ_ACC_EN
      test_acc();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
